serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx_if.sv | 22 ++
 rtl/serial_frame_rx.sv | 141 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Serial frame receiver bus: serial input, consumer ack, received word.
// Master drives the line and the acknowledge; slave is the receiver.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              serIn;
  logic              transmitted;
  logic              seroutvalid;
  logic [DATA_W-1:0] dataOut;
  logic              busy;
  logic              frameErr;

  modport master (
    output serIn, transmitted,
    input  seroutvalid, dataOut, busy, frameErr
  );

  modport slave (
    input  serIn, transmitted,
    output seroutvalid, dataOut, busy, frameErr
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: zero preamble, start bit, MSB-first payload.
// Define PARITY_EN to add an even-parity bit after the payload.
module serial_frame_rx #(
  parameter int DATA_W  = 8,
  parameter int PRE_LEN = 2
) (
  input logic             clk,
  input logic             rst,
  serial_frame_rx_if.slave rx
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int ZW = $clog2(PRE_LEN + 1);
  localparam logic [BW-1:0] LAST  = BW'(DATA_W - 1);
  localparam logic [ZW-1:0] ZLAST = ZW'(PRE_LEN - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    VALID = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    VALID = 3'd4
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ZW-1:0]     zcnt_q, zcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] sh_nxt;
`ifdef PARITY_EN
  logic              err_q, err_d;
`endif

  assign sh_nxt = DATA_W'({sh_q, rx.serIn});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      zcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
`ifdef PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
`ifdef PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  // zero counter only runs in IDLE, so VALID-time bits never count
  always_comb begin
    state_d = state_q;
    zcnt_d  = '0;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
`ifdef PARITY_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx.serIn) begin
          if (zcnt_q == ZLAST) state_d = SYNC;
          else zcnt_d = zcnt_q + 1'b1;
        end
      end
      SYNC: begin
        if (rx.serIn) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        sh_d   = sh_nxt;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == LAST) begin
`ifdef PARITY_EN
          state_d = PAR;
`else
          state_d = VALID;
          dout_d  = sh_nxt;
`endif
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (^{sh_q, rx.serIn}) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = VALID;
          dout_d  = sh_q;
        end
      end
`endif
      VALID: begin
        if (rx.transmitted) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx.seroutvalid = 1'b0;
    rx.busy        = 1'b0;
    unique case (state_q)
      DATA:    rx.busy = 1'b1;
`ifdef PARITY_EN
      PAR:     rx.busy = 1'b1;
`endif
      VALID:   rx.seroutvalid = 1'b1;
      default: ;
    endcase
  end

  assign rx.dataOut = dout_q;
`ifdef PARITY_EN
  assign rx.frameErr = err_q;
`else
  assign rx.frameErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: 8-bit/PRE_LEN=2 and 16-bit/PRE_LEN=4 copies.
// Expected words go to a queue when sent and are popped on seroutvalid.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_frame_rx_if #(.DATA_W(8))  a ();
  serial_frame_rx_if #(.DATA_W(16)) b ();

  serial_frame_rx #(.DATA_W(8), .PRE_LEN(2)) dut_a (
    .clk(clk), .rst(rst), .rx(a)
  );
  serial_frame_rx #(.DATA_W(16), .PRE_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .rx(b)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic [7:0]  e8;
  logic [15:0] e16;
  int vcnt = 0;
  bit vmon = 1'b0;

  always @(negedge clk) if (vmon && a.seroutvalid) vcnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit8(input logic v);
    a.serIn = v;
    tick();
  endtask

  task automatic bit16(input logic v);
    b.serIn = v;
    tick();
  endtask

  task automatic body8(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) bit8(d[i]);
`ifdef PARITY_EN
    bit8(^d);
`endif
  endtask

  task automatic ack8();
    a.transmitted = 1'b1;
    tick();
    a.transmitted = 1'b0;
    a.serIn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a.serIn = 1'b1; a.transmitted = 1'b0;
    b.serIn = 1'b1; b.transmitted = 1'b0;
    tick(); tick();
    checks++;
    if (a.seroutvalid !== 1'b0) begin
      failures++; $display("FAIL rst_valid got=%b exp=0", a.seroutvalid);
    end
    checks++;
    if (a.dataOut !== 8'h00) begin
      failures++; $display("FAIL rst_dout got=%h exp=00", a.dataOut);
    end
    checks++;
    if (a.busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy got=%b exp=0", a.busy);
    end
    checks++;
    if (a.frameErr !== 1'b0) begin
      failures++; $display("FAIL rst_err got=%b exp=0", a.frameErr);
    end
    checks++;
    if (b.dataOut !== 16'h0000) begin
      failures++; $display("FAIL rst_dout16 got=%h exp=0000", b.dataOut);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'hA5;
    q8.push_back(d);
    bit8(0); bit8(0); bit8(1);
    for (int i = 7; i >= 1; i--) bit8(d[i]);
    checks++;
    if (a.busy !== 1'b1 || a.seroutvalid !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got=%b/%b exp=1/0", a.busy, a.seroutvalid);
    end
    bit8(d[0]);
`ifdef PARITY_EN
    bit8(^d);
`endif
    checks++;
    if (a.seroutvalid !== 1'b1) begin
      failures++; $display("FAIL basic_latency got=%b exp=1", a.seroutvalid);
    end
    e8 = q8.pop_front();
    checks++;
    if (a.dataOut !== e8) begin
      failures++; $display("FAIL basic_dout got=%h exp=%h", a.dataOut, e8);
    end
    a.serIn = 1'b0;
    repeat (3) tick();
    checks++;
    if (a.seroutvalid !== 1'b1 || a.dataOut !== e8) begin
      failures++;
      $display("FAIL basic_hold got=%b/%h exp=1/%h", a.seroutvalid, a.dataOut, e8);
    end
    a.transmitted = 1'b1;
    tick();
    a.transmitted = 1'b0;
    checks++;
    if (a.seroutvalid !== 1'b0) begin
      failures++; $display("FAIL basic_drop got=%b exp=0", a.seroutvalid);
    end
    checks++;
    if (a.dataOut !== 8'hA5) begin
      failures++; $display("FAIL basic_keep got=%h exp=a5", a.dataOut);
    end
    bit8(0); bit8(1);
    checks++;
    if (a.busy !== 1'b0) begin
      failures++; $display("FAIL valid_zeros_counted got=%b exp=0", a.busy);
    end
    bit8(1); bit8(1);
  endtask

  task automatic test_long_preamble();
    q8.push_back(8'h3C);
    bit8(0); bit8(1); bit8(0); bit8(0); bit8(0); bit8(0); bit8(1);
    body8(8'h3C);
    checks++;
    if (a.seroutvalid !== 1'b1) begin
      failures++; $display("FAIL long_valid got=%b exp=1", a.seroutvalid);
    end
    e8 = q8.pop_front();
    checks++;
    if (a.dataOut !== e8) begin
      failures++; $display("FAIL long_dout got=%h exp=%h", a.dataOut, e8);
    end
    ack8();
    bit8(1);
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    q8.push_back(8'hA5);
    bit8(0); bit8(0); bit8(1);
    body8(8'hA5);
    e8 = q8.pop_front();
    checks++;
    if (a.seroutvalid !== 1'b1 || a.dataOut !== e8) begin
      failures++;
      $display("FAIL par_good got=%b/%h exp=1/%h", a.seroutvalid, a.dataOut, e8);
    end
    ack8();
    bit8(1);
    bit8(0); bit8(0); bit8(1);
    for (int i = 7; i >= 0; i--) bit8(e8 ^ 8'hFF ? ((8'h5A >> i) & 1) : 1'b0);
    bit8(~^8'h5A);
    checks++;
    if (a.frameErr !== 1'b1) begin
      failures++; $display("FAIL par_err got=%b exp=1", a.frameErr);
    end
    checks++;
    if (a.seroutvalid !== 1'b0) begin
      failures++; $display("FAIL par_valid got=%b exp=0", a.seroutvalid);
    end
    checks++;
    if (a.dataOut !== 8'hA5) begin
      failures++; $display("FAIL par_dout got=%h exp=a5", a.dataOut);
    end
    bit8(1);
    checks++;
    if (a.frameErr !== 1'b0) begin
      failures++; $display("FAIL par_pulse got=%b exp=0", a.frameErr);
    end
  endtask
`endif

  task automatic test_reset_midframe();
    bit8(0); bit8(0); bit8(1);
    bit8(1); bit8(1); bit8(0); bit8(1);
    rst = 1'b1;
    tick();
    checks++;
    if (a.busy !== 1'b0 || a.seroutvalid !== 1'b0 || a.frameErr !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_ctl got=%b%b%b exp=000", a.busy, a.seroutvalid, a.frameErr);
    end
    checks++;
    if (a.dataOut !== 8'h00) begin
      failures++; $display("FAIL mid_rst_dout got=%h exp=00", a.dataOut);
    end
    rst = 1'b0;
    bit8(1);
    q8.push_back(8'hFF);
    bit8(0); bit8(0); bit8(1);
    body8(8'hFF);
    e8 = q8.pop_front();
    checks++;
    if (a.seroutvalid !== 1'b1 || a.dataOut !== e8) begin
      failures++;
      $display("FAIL mid_after got=%b/%h exp=1/%h", a.seroutvalid, a.dataOut, e8);
    end
    ack8();
    bit8(1);
  endtask

  task automatic test_ack_held();
    logic [7:0] w [2];
    w[0] = 8'h5A; w[1] = 8'hC3;
    a.transmitted = 1'b1;
    vcnt = 0;
    vmon = 1'b1;
    for (int f = 0; f < 2; f++) begin
      q8.push_back(w[f]);
      bit8(0); bit8(0); bit8(1);
      body8(w[f]);
      e8 = q8.pop_front();
      checks++;
      if (a.seroutvalid !== 1'b1 || a.dataOut !== e8) begin
        failures++;
        $display("FAIL held_word%0d got=%b/%h exp=1/%h", f, a.seroutvalid, a.dataOut, e8);
      end
      bit8(1);
      checks++;
      if (a.seroutvalid !== 1'b0) begin
        failures++; $display("FAIL held_drop%0d got=%b exp=0", f, a.seroutvalid);
      end
    end
    tick();
    vmon = 1'b0;
    a.transmitted = 1'b0;
    checks++;
    if (vcnt !== 2) begin
      failures++; $display("FAIL held_count got=%0d exp=2", vcnt);
    end
  endtask

  task automatic test_wide();
    bit16(0); bit16(0); bit16(0); bit16(1);
    bit16(1); bit16(0); bit16(1);
    checks++;
    if (b.busy !== 1'b0) begin
      failures++; $display("FAIL wide_short_pre got=%b exp=0", b.busy);
    end
    bit16(1);
    q16.push_back(16'hBEEF);
    bit16(0); bit16(0); bit16(0); bit16(0); bit16(1);
    for (int i = 15; i >= 0; i--) begin
      e16 = 16'hBEEF;
      bit16(e16[i]);
    end
`ifdef PARITY_EN
    bit16(^16'hBEEF);
`endif
    e16 = q16.pop_front();
    checks++;
    if (b.seroutvalid !== 1'b1) begin
      failures++; $display("FAIL wide_valid got=%b exp=1", b.seroutvalid);
    end
    checks++;
    if (b.dataOut !== e16) begin
      failures++; $display("FAIL wide_dout got=%h exp=%h", b.dataOut, e16);
    end
    b.transmitted = 1'b1;
    tick();
    b.transmitted = 1'b0;
    checks++;
    if (b.seroutvalid !== 1'b0) begin
      failures++; $display("FAIL wide_ack got=%b exp=0", b.seroutvalid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_preamble();
`ifdef PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    test_ack_held();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
